// File: rtl/tx_lp_clk_fsm.sv
// Transmit clock-lane sequencer: walks CLKDp/CLKDn through LP->HS entry,
// continuous HS clock and HS->LP exit under an hs_req level handshake.
module tx_lp_clk_fsm #(
  parameter int unsigned T_LPX         = 2,
  parameter int unsigned T_CLK_PREPARE = 4,
  parameter int unsigned T_CLK_ZERO    = 6,
  parameter int unsigned T_CLK_POST    = 4,
  parameter int unsigned T_CLK_TRAIL   = 3,
  parameter int unsigned T_HS_EXIT     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_req,
  output logic       hs_ack,
  output logic       hs_active,
  output logic       CLKDp,
  output logic       CLKDn,
  output logic [2:0] state_dbg
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STATE_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [STATE_W-1:0] {
    STOP     = 3'd0,
    HS_RQST  = 3'd1,
    HS_PRPR  = 3'd2,
    HS_ZERO  = 3'd3,
    HS_CLK   = 3'd4,
    HS_POST  = 3'd5,
    HS_TRAIL = 3'd6,
    HS_EXIT  = 3'd7
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tgl;
  logic             tgl_nxt;

  // A timed state has run its full dwell on the cycle where cnt == len-1.
  function automatic logic dwell_done(input logic [CNT_W-1:0] c, input int unsigned len);
    return c == CNT_W'(len - 1);
  endfunction

  // Lane levels {CLKDp, CLKDn} for a given state and toggle phase.
  function automatic logic [1:0] lane_level(input state_t s, input logic t);
    logic [1:0] lv;
    lv = 2'b11;
    unique case (s)
      STOP, HS_EXIT:     lv = 2'b11;
      HS_RQST:           lv = 2'b01;
      HS_PRPR:           lv = 2'b00;
      HS_ZERO, HS_TRAIL: lv = 2'b01;
      HS_CLK, HS_POST:   lv = {t, ~t};
      default:           lv = 2'b11;
    endcase
    return lv;
  endfunction

  // Next-state, dwell counter and toggle update.
  always_comb begin
    state_nxt = state;
    unique case (state)
      STOP:     if (hs_req)                           state_nxt = HS_RQST;
      HS_RQST:  if (dwell_done(cnt, T_LPX))           state_nxt = HS_PRPR;
      HS_PRPR:  if (dwell_done(cnt, T_CLK_PREPARE))   state_nxt = HS_ZERO;
      HS_ZERO:  if (dwell_done(cnt, T_CLK_ZERO))      state_nxt = HS_CLK;
      HS_CLK:   if (!hs_req)                          state_nxt = HS_POST;
      HS_POST:  if (dwell_done(cnt, T_CLK_POST))      state_nxt = HS_TRAIL;
      HS_TRAIL: if (dwell_done(cnt, T_CLK_TRAIL))     state_nxt = HS_EXIT;
      HS_EXIT:  if (dwell_done(cnt, T_HS_EXIT))       state_nxt = STOP;
      default:                                        state_nxt = STOP;
    endcase

    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else begin
      cnt_nxt = cnt;
    end

    // Toggle runs through HS_CLK into HS_POST and is parked at 0 elsewhere.
    tgl_nxt = 1'b0;
    if ((state == HS_CLK || state == HS_POST) && state_nxt != HS_TRAIL) begin
      tgl_nxt = ~tgl;
    end
  end

  // Outputs are registered from the next state so they always match state/tgl.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STOP;
      cnt       <= '0;
      tgl       <= 1'b0;
      CLKDp     <= 1'b1;
      CLKDn     <= 1'b1;
      hs_ack    <= 1'b0;
      hs_active <= 1'b0;
      state_dbg <= STATE_W'(STOP);
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      tgl            <= tgl_nxt;
      {CLKDp, CLKDn} <= lane_level(state_nxt, tgl_nxt);
      hs_ack         <= (state_nxt == HS_CLK);
      hs_active      <= (state_nxt != STOP) && (state_nxt != HS_EXIT);
      state_dbg      <= STATE_W'(state_nxt);
    end
  end

endmodule
